bram_stream_reader: RTL and testbench

- Read-side sequencer for the team's single-port block RAM.
- On a start command it walks a contiguous address range, absorbs the RAM's one-cycle registered read latency, and streams the words out on a valid/ready interface with a last marker.
- Sits between a block RAM instance and a downstream consumer such as a UART TX or DMA path.
- Owns the RAM port outright while busy.

---
 rtl/bram_reader_pkg.sv | 14 +
 rtl/bram_stream_reader_if.sv | 14 +
 rtl/stream_skid_fifo.sv | 48 ++++
 rtl/bram_stream_reader.sv | 130 +++++++++++++
 tb/tb_bram_stream_reader.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/bram_reader_pkg.sv
// Shared definitions for the block-RAM stream reader: FSM encoding and skid FIFO sizing.
package bram_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready stream carrying one RAM word plus a last marker.
interface bram_stream_reader_if #(
   parameter int unsigned RAM_WIDTH = 8
) ();

   logic [RAM_WIDTH-1:0] m_data;
   logic                 m_valid;
   logic                 m_ready;
   logic                 m_last;

   modport master (output m_data, output m_valid, output m_last, input m_ready);
   modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO with registered head outputs; head data is stable until popped.
module stream_skid_fifo
   import bram_reader_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      head_data,
   output logic                  head_valid,
   output logic [FIFO_CNT_W-1:0] count
);

   logic [WIDTH-1:0]      tail_data;
   logic [FIFO_CNT_W-1:0] count_next;

   always_comb begin
      count_next = count + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
   end

   // Callers only pop when head_valid and only push when there is room.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_data  <= '0;
         tail_data  <= '0;
         head_valid <= 1'b0;
         count      <= '0;
      end else begin
         count      <= count_next;
         head_valid <= (count_next != '0);
         if (pop) begin
            if (count == FIFO_CNT_W'(2)) begin
               head_data <= tail_data;
               if (push) tail_data <= push_data;
            end else if (push) begin
               head_data <= push_data;
            end
         end else if (push) begin
            if (count == '0) head_data <= push_data;
            else             tail_data <= push_data;
         end
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a wrapping address range of a registered-read block RAM and streams the words out.
// Build option BRAM_STREAM_READER_CLEAR_EN zeroes each location as it is read.
module bram_stream_reader
   import bram_reader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned RAM_WIDTH  = 8,
   parameter int unsigned RAM_DEPTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_wen,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [RAM_WIDTH-1:0]  ram_wdata,
   input  logic [RAM_WIDTH-1:0]  ram_rdata,
   bram_stream_reader_if.master  m
);

   localparam int unsigned LEN_W = ADDR_WIDTH + 1;
   localparam int unsigned PLD_W = RAM_WIDTH + 1;
   localparam int unsigned OCC_W = FIFO_CNT_W + 1;

   state_e state, state_next;

   logic [LEN_W-1:0]      len_q;
   logic [LEN_W-1:0]      issued;
   logic                  inflight;
   logic                  inflight_last;
   logic                  issue;
   logic                  last_issue;
   logic                  pop;
   logic [OCC_W-1:0]      occupancy;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic                  busy_d;
   logic                  done_d;

   logic [FIFO_CNT_W-1:0] fifo_count;
   logic                  fifo_valid;
   logic [PLD_W-1:0]      fifo_data;

   // Issue only while the buffer can absorb the word once it lands.
   always_comb begin
      pop        = fifo_valid & m.m_ready;
      occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight);
      issue      = (state == ST_READ) && (issued < len_q) &&
                   (occupancy < (OCC_W'(FIFO_DEPTH) + OCC_W'(pop)));
      last_issue = issue && (issued == (len_q - LEN_W'(1)));
      addr_next  = (ram_addr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : ram_addr + ADDR_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:  if (start) state_next = (len == '0) ? ST_DONE : ST_READ;
         ST_READ:  if (last_issue) state_next = ST_DRAIN;
         ST_DRAIN: if (!inflight && (fifo_count == FIFO_CNT_W'(pop))) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      if (state_next != ST_IDLE) busy_d = 1'b1;
      if (state_next == ST_DONE) done_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy          <= 1'b0;
         done          <= 1'b0;
         ram_addr      <= '0;
         len_q         <= '0;
         issued        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         busy          <= busy_d;
         done          <= done_d;
         inflight      <= issue;
         inflight_last <= last_issue;
         if ((state == ST_IDLE) && start) begin
            ram_addr <= start_addr;
            len_q    <= len;
            issued   <= '0;
         end else if (issue) begin
            ram_addr <= addr_next;
            issued   <= issued + LEN_W'(1);
         end
      end
   end

   stream_skid_fifo #(
      .WIDTH (PLD_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (inflight),
      .push_data  ({inflight_last, ram_rdata}),
      .pop        (pop),
      .head_data  (fifo_data),
      .head_valid (fifo_valid),
      .count      (fifo_count)
   );

   assign m.m_valid = fifo_valid;
   assign m.m_data  = fifo_data[RAM_WIDTH-1:0];
   assign m.m_last  = fifo_data[RAM_WIDTH];

   // Write strobe must coincide with the read address, so it follows issue directly.
`ifdef BRAM_STREAM_READER_CLEAR_EN
   assign ram_wen   = issue & ~rst;
   assign ram_wdata = '0;
`else
   assign ram_wen   = 1'b0;
   assign ram_wdata = '0;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader against a read-first registered RAM model.
module tb_bram_stream_reader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] start_addr = '0;
   logic [4:0] len = '0;
   logic       m_ready = 1'b0;
   logic       reload = 1'b0;
   logic       busy, done, ram_wen;
   logic [3:0] ram_addr;
   logic [7:0] ram_wdata, ram_rdata;
   logic [7:0] mem [16];

   bram_stream_reader_if #(.RAM_WIDTH(8)) s_if ();
   assign s_if.m_ready = m_ready;

   bram_stream_reader #(.ADDR_WIDTH(4), .RAM_WIDTH(8), .RAM_DEPTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .ram_wen    (ram_wen),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .m          (s_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'(i + 16);
         ram_rdata <= '0;
      end else begin
         ram_rdata <= mem[ram_addr];
         if (ram_wen) mem[ram_addr] <= ram_wdata;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [7:0] q_data [$];
   logic       q_last [$];
   int         first_valid, done_cyc, last_hs;
   logic       busy_c1, wen_seen;

   task automatic run_xfer(input logic [3:0] a, input logic [4:0] n, input int mode);
      logic pv, ph, pl, fin;
      logic [7:0] pd;
      q_data.delete();
      q_last.delete();
      first_valid = -1; done_cyc = -1; last_hs = -1;
      busy_c1 = 1'b0; wen_seen = 1'b0;
      pv = 1'b0; ph = 1'b0; pl = 1'b0; pd = '0; fin = 1'b0;
      @(negedge clk);
      start = 1'b1; start_addr = a; len = n; m_ready = 1'b1;
      for (int c = 1; c <= 300 && !fin; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (mode == 1) m_ready = (c >= 4 && c < 14) ? 1'b0 : 1'($urandom_range(0, 1));
         else           m_ready = 1'b1;
         #1;
         if (c == 1) busy_c1 = busy;
         if (ram_wen) wen_seen = 1'b1;
         if (pv && !ph) begin
            check("hold_valid", 32'(s_if.m_valid), 32'd1);
            check("hold_data", 32'(s_if.m_data), 32'(pd));
            check("hold_last", 32'(s_if.m_last), 32'(pl));
         end
         if (s_if.m_valid && first_valid < 0) first_valid = c;
         if (done) begin
            done_cyc = c;
            fin = 1'b1;
         end
         ph = s_if.m_valid & m_ready;
         pv = s_if.m_valid;
         pd = s_if.m_data;
         pl = s_if.m_last;
         if (ph) begin
            q_data.push_back(s_if.m_data);
            q_last.push_back(s_if.m_last);
            last_hs = c;
         end
      end
      check("finished", 32'(fin), 32'd1);
      @(negedge clk);
      #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
   endtask

   task automatic expect_stream(input string t, input int a, input int n, input bit zero);
      logic [7:0] exp;
      check({t, "_count"}, 32'(q_data.size()), 32'(n));
      for (int i = 0; i < n && i < q_data.size(); i++) begin
         exp = zero ? 8'h00 : 8'(((a + i) % 16) + 16);
         check({t, "_data"}, 32'(q_data[i]), 32'(exp));
         check({t, "_last"}, 32'(q_last[i]), 32'(i == n - 1));
      end
   endtask

   initial begin
      int  hs;
      logic seen;
      reload = 1'b1;
      repeat (3) @(negedge clk);
      reload = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wen", 32'(ram_wen), 32'd0);
      check("rst_addr", 32'(ram_addr), 32'd0);
      check("rst_wdata", 32'(ram_wdata), 32'd0);
      check("rst_mdata", 32'(s_if.m_data), 32'd0);
      check("rst_mvalid", 32'(s_if.m_valid), 32'd0);
      check("rst_mlast", 32'(s_if.m_last), 32'd0);
      rst = 1'b0;

      // Basic run: 0x13..0x16 back to back
      run_xfer(4'd3, 5'd4, 0);
      expect_stream("t1", 3, 4, 1'b0);
      check("t1_first_valid", 32'(first_valid), 32'd3);
      check("t1_last_hs", 32'(last_hs), 32'd6);
      check("t1_done", 32'(done_cyc), 32'd7);
      check("t1_busy", 32'(busy_c1), 32'd1);

      // Address wrap 14,15,0,1
      run_xfer(4'd14, 5'd4, 0);
      expect_stream("t2", 14, 4, 1'b0);
      check("t2_done", 32'(done_cyc), 32'd7);

      // Zero length
      run_xfer(4'd5, 5'd0, 0);
      check("t3_no_valid", 32'(first_valid), 32'hFFFF_FFFF);
      check("t3_count", 32'(q_data.size()), 32'd0);
      check("t3_busy", 32'(busy_c1), 32'd1);
      check("t3_done", 32'(done_cyc), 32'd1);

      // Backpressure: random ready plus a 10-cycle stall
      run_xfer(4'd5, 5'd8, 1);
      expect_stream("t4", 5, 8, 1'b0);
      check("t4_done_after_last", 32'(done_cyc), 32'(last_hs + 1));

      // Reset during beat 3 aborts without done
      @(negedge clk);
      start = 1'b1; start_addr = 4'd0; len = 5'd8; m_ready = 1'b1;
      hs = 0;
      for (int c = 0; c < 20 && hs < 3; c++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (s_if.m_valid && m_ready) hs++;
      end
      check("t5_reached_beat3", 32'(hs), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_mvalid", 32'(s_if.m_valid), 32'd0);
      check("t5_mdata", 32'(s_if.m_data), 32'd0);
      check("t5_mlast", 32'(s_if.m_last), 32'd0);
      check("t5_addr", 32'(ram_addr), 32'd0);
      check("t5_wen", 32'(ram_wen), 32'd0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         #1;
         if (done || s_if.m_valid) seen = 1'b1;
      end
      check("t5_quiet", 32'(seen), 32'd0);
      run_xfer(4'd9, 5'd3, 0);
      expect_stream("t5b", 9, 3, 1'b0);
      check("t5b_first_valid", 32'(first_valid), 32'd3);

      // Full depth, twice; second pass is zero only when clear-on-read is built in
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      run_xfer(4'd0, 5'd16, 0);
      expect_stream("t6a", 0, 16, 1'b0);
`ifdef BRAM_STREAM_READER_CLEAR_EN
      check("t6a_wen", 32'(wen_seen), 32'd1);
      run_xfer(4'd0, 5'd16, 0);
      expect_stream("t6b", 0, 16, 1'b1);
`else
      check("t6a_wen", 32'(wen_seen), 32'd0);
      run_xfer(4'd0, 5'd16, 0);
      expect_stream("t6b", 0, 16, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
